// File: rtl/wired_inst_buffer_pkg.sv
// Shared types and helpers for the wired instruction buffer.
// Default sizes, pointer/count typedefs, and a lane popcount.
package wired_inst_buffer_pkg;

   localparam int IBUF_DEPTH = 16;
   localparam int IBUF_PKG_W = 64;
   localparam int IBUF_PTR_W = $clog2(IBUF_DEPTH);
   localparam int IBUF_CNT_W = IBUF_PTR_W + 1;
   localparam int LANE_CNT_W = 4;

   typedef logic [IBUF_PKG_W-1:0] pipeline_ctrl_pack_t;
   typedef logic [IBUF_PTR_W-1:0] ibuf_ptr_t;
   typedef logic [IBUF_CNT_W-1:0] ibuf_cnt_t;
   typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

   // Lane masks are at most 8 wide; narrower masks are zero-extended by the caller.
   function automatic lane_cnt_t popcount8(input logic [7:0] v);
      lane_cnt_t n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + LANE_CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/wired_ibuf_compactor.sv
// Prefix popcount over the fetch mask: slot offset of each set lane
// relative to tail, plus the total number of instructions pushed.
module wired_ibuf_compactor
   import wired_inst_buffer_pkg::*;
#(
   parameter int FETCH_WIDTH = 2
) (
   input  logic [FETCH_WIDTH-1:0]                 mask,
   output logic [FETCH_WIDTH-1:0][LANE_CNT_W-1:0] offset,
   output lane_cnt_t                              total
);

   lane_cnt_t run_s;

   // Exclusive prefix sum: lane i lands after all set lanes below it.
   always_comb begin
      run_s = 4'd0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         offset[i] = run_s;
         run_s     = run_s + LANE_CNT_W'(mask[i]);
      end
      total = popcount8(8'(mask));
   end

endmodule

// File: rtl/wired_inst_buffer.sv
// Per-instruction circular buffer between packer and dispatch.
// Optional epoch filtering of stale fetches: WIRED_IBUF_TID_FILTER_EN.
module wired_inst_buffer
   import wired_inst_buffer_pkg::*;
#(
   parameter int FETCH_WIDTH  = 2,
   parameter int DECODE_WIDTH = 2,
   parameter int DEPTH        = IBUF_DEPTH,
   parameter int PKG_W        = IBUF_PKG_W,
   parameter int TID_W        = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush_i,
   input  logic [TID_W-1:0]              flush_tid_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [FETCH_WIDTH-1:0]        in_mask_i,
   input  logic [FETCH_WIDTH*PKG_W-1:0]  in_pkg_i,
   input  logic [TID_W-1:0]              in_tid_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DECODE_WIDTH-1:0]       out_mask_o,
   output logic [DECODE_WIDTH*PKG_W-1:0] out_pkg_o,
   output logic [$clog2(DEPTH):0]        count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PKG_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;

   logic [FETCH_WIDTH-1:0]                 push_mask_s;
   logic [FETCH_WIDTH-1:0][LANE_CNT_W-1:0] lane_off_s;
   lane_cnt_t                              push_cnt_s;
   logic                                   push_s;
   logic                                   pop_s;
   logic [CNT_W-1:0]                       pop_cnt_s;
   logic [CNT_W-1:0]                       push_add_s;
   logic [CNT_W-1:0]                       pop_sub_s;

`ifdef WIRED_IBUF_TID_FILTER_EN
   logic [TID_W-1:0] epoch_r;

   // Epoch tag of the current fetch stream, replaced on every redirect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         epoch_r <= {TID_W{1'b0}};
      end else if (flush_i) begin
         epoch_r <= flush_tid_i;
      end else begin
         epoch_r <= epoch_r;
      end
   end

   // Stale packets are still consumed so the upstream stage drains them.
   always_comb begin
      if (in_tid_i != epoch_r) begin
         push_mask_s = {FETCH_WIDTH{1'b0}};
      end else begin
         push_mask_s = in_mask_i;
      end
   end
`else
   logic unused_tid_s;
   assign unused_tid_s = ^{in_tid_i, flush_tid_i};
   assign push_mask_s  = in_mask_i;
`endif

   wired_ibuf_compactor #(
      .FETCH_WIDTH (FETCH_WIDTH)
   ) u_compactor (
      .mask   (push_mask_s),
      .offset (lane_off_s),
      .total  (push_cnt_s)
   );

   // Handshakes depend on registered count only, so nothing combinational crosses the buffer.
   always_comb begin
      in_ready_o  = (CNT_W'(DEPTH) - count_r) >= CNT_W'(FETCH_WIDTH);
      out_valid_o = (count_r != {CNT_W{1'b0}});
      push_s      = in_valid_i && in_ready_o;
      pop_s       = out_valid_o && out_ready_i;
      if (count_r < CNT_W'(DECODE_WIDTH)) begin
         pop_cnt_s = count_r;
      end else begin
         pop_cnt_s = CNT_W'(DECODE_WIDTH);
      end
      if (push_s) begin
         push_add_s = CNT_W'(push_cnt_s);
      end else begin
         push_add_s = {CNT_W{1'b0}};
      end
      if (pop_s) begin
         pop_sub_s = pop_cnt_s;
      end else begin
         pop_sub_s = {CNT_W{1'b0}};
      end
   end

   // Oldest DECODE_WIDTH slots, wrapping through the pointer width.
   always_comb begin
      for (int k = 0; k < DECODE_WIDTH; k++) begin
         out_mask_o[k]               = (CNT_W'(k) < count_r);
         out_pkg_o[k*PKG_W +: PKG_W] = mem_r[head_r + PTR_W'(k)];
      end
   end

   assign count_o = count_r;

   // Pointer and occupancy update; flush wins over push and pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (flush_i) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         head_r  <= head_r + PTR_W'(pop_sub_s);
         tail_r  <= tail_r + PTR_W'(push_add_s);
         count_r <= count_r + push_add_s - pop_sub_s;
      end
   end

   // Payload store; set lanes land in compacted order starting at tail.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (rst_n && !flush_i && push_s && push_mask_s[i]) begin
            mem_r[tail_r + PTR_W'(lane_off_s[i])] <= in_pkg_i[i*PKG_W +: PKG_W];
         end
      end
   end

endmodule

// File: doc/wired_inst_buffer.md
Name: wired_inst_buffer

Overview:
Parametrised instruction buffer between the decode/packer stage and the backend dispatch port. It is the successor to the fixed 2-wide, packet-granular frontend FIFO.
- Accepts FETCH_WIDTH-lane masked fetch packets.
- Compacts the valid lanes into a circular per-instruction store.
- Emits up to DECODE_WIDTH contiguous instructions per cycle.
- Packet boundaries are not preserved, so sparse fetch packets no longer waste dispatch bandwidth.

Parameters:
FETCH_WIDTH, 2, lanes per input packet (1..8)
DECODE_WIDTH, 2, lanes per output group (1..8)
DEPTH, 16, instruction slots; power of two, >= FETCH_WIDTH + DECODE_WIDTH
PKG_W, 64, bits per instruction payload (pipeline control pack width)
TID_W, 1, width of the fetch-epoch tag

Ports:
clk  input  1  clock
rst_n  input  1  reset
flush_i  input  1  frontend redirect; clears the buffer
flush_tid_i  input  TID_W  new epoch tag, valid with flush_i
in_valid_i  input  1  input packet valid
in_ready_o  output  1  buffer can absorb a full packet
in_mask_i  input  FETCH_WIDTH  per-lane valid; may be sparse
in_pkg_i  input  FETCH_WIDTH*PKG_W  lane payloads, lane 0 in LSBs
in_tid_i  input  TID_W  epoch tag of the input packet
out_valid_o  output  1  at least one instruction held
out_ready_i  input  1  backend accepts the whole output group
out_mask_o  output  DECODE_WIDTH  contiguous low-order valid lanes
out_pkg_o  output  DECODE_WIDTH*PKG_W  oldest instructions, lane 0 oldest
count_o  output  $clog2(DEPTH)+1  occupied slots

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - head, tail and count are set to 0; the epoch register is set to 0.
  - After reset: out_valid_o=0, out_mask_o=0, in_ready_o=1, count_o=0.
- Storage: DEPTH x PKG_W register array. head and tail are $clog2(DEPTH)-bit pointers that wrap modulo DEPTH. count is tracked separately, so full and empty are never ambiguous.
- in_ready_o = (DEPTH - count) >= FETCH_WIDTH. It is computed from registered count only; there is no combinational path from out_ready_i.
- Push occurs when in_valid_i && in_ready_o.
  - Set lanes of in_mask_i are written, in lane order, to slots tail, tail+1, ... (mod DEPTH).
  - The offset for lane i is popcount(in_mask_i[i-1:0]).
  - tail advances by popcount(in_mask_i).
  - A packet with an all-zero mask is consumed and stores nothing.
- Output is a combinational read of slots head .. head+DECODE_WIDTH-1.
  - out_mask_o[k] = (k < count).
  - out_valid_o = (count != 0).
  - Lanes not set in out_mask_o carry don't-care payload.
- Pop occurs when out_valid_o && out_ready_i.
  - head advances by popcount(out_mask_o); all masked lanes leave together.
  - There are no partial pops.
- Latency: an instruction pushed in cycle N is visible on the output in cycle N+1. There is no bypass.
- Push and pop may occur in the same cycle: count_next = count + pushed - popped. Because in_ready_o is based on the pre-pop count, overflow is impossible.
- Flush (flush_i=1):
  - In the following cycle, head=tail=count=0.
  - Any push or pop in the flush cycle is discarded.
  - in_ready_o stays as computed, so the upstream stage may drop its packet.
  - The epoch register captures flush_tid_i.
- flush_i takes priority over push and pop. rst_n takes priority over flush_i.

Optional Feature:
WIRED_IBUF_TID_FILTER_EN
- Defined: a packet accepted while in_tid_i != epoch register is treated as an all-zero mask. It is consumed but nothing is stored, which drains stale in-flight fetches after a redirect.
- Undefined: in_tid_i is ignored, and the epoch register is not synthesised.

Decomposition:
- The shared package (alongside pipeline_ctrl_pack_t) holds:
  - ibuf pointer/count typedefs derived from DEPTH;
  - the default DEPTH constant;
  - a popcount function.
- One natural sub-module, wired_ibuf_compactor: a combinational prefix-popcount that maps input lanes to slot offsets and outputs the total push count.

Test Plan:
- Reset, then idle: out_valid_o=0, in_ready_o=1, count_o=0 throughout.
- Push mask 2'b11 (A,B), then 2'b10 (C), with out_ready_i=0: count_o=3. Output lanes are A,B, out_mask_o=2'b11. After one pop the output is C with out_mask_o=2'b01.
- Fill with out_ready_i=0 (DEPTH=16, FW=2): in_ready_o drops when count_o=15 or 16. Continuous push/pop at full rate then holds count_o steady, and payload order is preserved across pointer wrap over 40 or more instructions.
- flush_i asserted in the same cycle as a push and a pop, with count=5: next cycle count_o=0, out_valid_o=0, and no flush-cycle data ever appears on the output.
- All-zero in_mask_i with in_valid_i=1: the packet is accepted and count_o is unchanged.
- With WIRED_IBUF_TID_FILTER_EN defined, flush with flush_tid_i=1, then push a packet with in_tid_i=0 followed by one with in_tid_i=1: only the second packet's lanes appear on the output.
